// File: rtl/audio_sample_feeder_if.sv
// audio_sample_feeder_if: song-memory read port of the audio sample feeder.
// Single outstanding request: the feeder holds mem_req/mem_addr until the
// memory answers with a one-cycle mem_ack carrying mem_data.
interface audio_sample_feeder_if #(
    parameter int ADDR_W = 18
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_req;
    logic              mem_ack;
    logic [15:0]       mem_data;

    modport master (
        output mem_addr,
        output mem_req,
        input  mem_ack,
        input  mem_data
    );

    modport slave (
        input  mem_addr,
        input  mem_req,
        output mem_ack,
        output mem_data
    );
endinterface

// File: rtl/audio_sample_feeder.sv
// audio_sample_feeder: streams signed PCM samples from song memory through a
// small FIFO and presents one offset-binary sample per sample period on
// PWM_out, with the play gate for the PWM DAC.
// Optional feature: define SAMPLE_VOLUME_EN to add the 4-bit volume port and
// scale each sample by (volume+1)/16 as it leaves the FIFO.
module audio_sample_feeder #(
    parameter int CLK_DIV    = 2267,
    parameter int ADDR_W     = 18,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk_in,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic [ADDR_W-1:0]    song_len,
`ifdef SAMPLE_VOLUME_EN
    input  logic [3:0]           volume,
`endif
    audio_sample_feeder_if.master bus,
    output logic [15:0]          PWM_out,
    output logic                 play,
    output logic                 busy,
    output logic                 underrun
);

    // state | meaning
    // IDLE  | not playing, waiting for a start with a non-zero length
    // FETCH | issue the next read as soon as the FIFO has a free slot
    // WAIT  | read outstanding, request held until mem_ack
    // DRAIN | every sample fetched, playing out what is left in the FIFO

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int                PTR_W     = $clog2(FIFO_DEPTH);
    localparam int                CNT_W     = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [PTR_W:0]    FIFO_CAP  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [15:0]       MIDSCALE  = 16'h8000;

    state_t            state;
    logic [ADDR_W-1:0] len;
    logic [ADDR_W-1:0] fetch_addr;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] addr_q;
    logic              req_q;
    logic [CNT_W-1:0]  tick_cnt;

    logic [15:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    fifo_count;

    logic              tick;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic [15:0]       head;
    logic [15:0]       scaled;

    assign bus.mem_req  = req_q;
    assign bus.mem_addr = addr_q;

    // The tick only exists while a song is playing; the counter parks at 0 otherwise.
    assign tick       = busy && (tick_cnt == TICK_LAST);
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == FIFO_CAP);
    // stop outranks a same-cycle ack, so the returned sample is dropped.
    assign push       = req_q && bus.mem_ack && !stop;
    assign pop        = tick && !fifo_empty && !stop;
    assign next_addr  = fetch_addr + ADDR_W'(1);
    assign head       = fifo_mem[rd_ptr];

`ifdef SAMPLE_VOLUME_EN
    // Gain is volume+1 in 1/16 steps; 20 bits hold s*16 for any 16-bit s.
    logic signed [19:0] head_ext;
    logic signed [19:0] gain_ext;
    logic signed [19:0] product;

    assign head_ext = {{4{head[15]}}, head};
    assign gain_ext = {15'd0, ({1'b0, volume} + 5'd1)};
    assign product  = head_ext * gain_ext;
    assign scaled   = 16'(product >>> 4);
`else
    assign scaled   = head;
`endif

    // Sample storage, written when a read completes.
    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.mem_data;
        end
    end

    // Playback FSM together with the tick counter, FIFO pointers and all registered outputs.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            len        <= '0;
            fetch_addr <= '0;
            addr_q     <= '0;
            req_q      <= 1'b0;
            tick_cnt   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            PWM_out    <= MIDSCALE;
            play       <= 1'b0;
            busy       <= 1'b0;
            underrun   <= 1'b0;
        end else if (stop) begin
            state      <= IDLE;
            req_q      <= 1'b0;
            tick_cnt   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            PWM_out    <= MIDSCALE;
            play       <= 1'b0;
            busy       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            underrun <= 1'b0;

            if (busy) begin
                tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
            end

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + PTR_W'(1);
                PWM_out <= {~scaled[15], scaled[14:0]};
                play    <= 1'b1;
            end
            fifo_count <= fifo_count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};

            case (state)
                IDLE: begin
                    if (start && (song_len != '0)) begin
                        len        <= song_len;
                        fetch_addr <= '0;
                        tick_cnt   <= '0;
                        wr_ptr     <= '0;
                        rd_ptr     <= '0;
                        fifo_count <= '0;
                        busy       <= 1'b1;
                        state      <= FETCH;
                    end
                end

                FETCH: begin
                    if (tick && fifo_empty) begin
                        underrun <= 1'b1;
                    end
                    if (!fifo_full) begin
                        req_q  <= 1'b1;
                        addr_q <= fetch_addr;
                        state  <= WAIT;
                    end
                end

                WAIT: begin
                    if (tick && fifo_empty) begin
                        underrun <= 1'b1;
                    end
                    if (bus.mem_ack) begin
                        req_q      <= 1'b0;
                        fetch_addr <= next_addr;
                        state      <= (next_addr == len) ? DRAIN : FETCH;
                    end
                end

                DRAIN: begin
                    // Song ends on the first tick that finds nothing left to play.
                    if (tick && fifo_empty) begin
                        PWM_out  <= MIDSCALE;
                        play     <= 1'b0;
                        busy     <= 1'b0;
                        tick_cnt <= '0;
                        state    <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_sample_feeder.sv
// Self-checking bench for audio_sample_feeder. A reactive memory model
// answers reads from a song array; a queue-based reference model predicts
// PWM_out, play, busy and underrun at every sample tick.
module tb_audio_sample_feeder;
    localparam int CLK_DIV    = 8;
    localparam int ADDR_W     = 8;
    localparam int FIFO_DEPTH = 8;

    logic              clk_in   = 1'b0;
    logic              reset_n  = 1'b0;
    logic              start    = 1'b0;
    logic              stop     = 1'b0;
    logic [ADDR_W-1:0] song_len = '0;
`ifdef SAMPLE_VOLUME_EN
    logic [3:0]        volume   = 4'd15;
`endif
    logic [15:0]       PWM_out;
    logic              play;
    logic              busy;
    logic              underrun;

    logic              ack_drv  = 1'b0;
    logic [15:0]       data_drv = 16'h0000;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] song [64];
    int          resp_mode     = 0;
    int          ack_delay     = 1;
    int          resp_wait     = 0;
    int          last_ack_addr = 0;
    bit          abort_done    = 1'b0;
    bit          stray_done    = 1'b0;

    audio_sample_feeder_if #(.ADDR_W(ADDR_W)) bus ();

    assign bus.mem_ack  = ack_drv;
    assign bus.mem_data = data_drv;

    audio_sample_feeder #(
        .CLK_DIV    (CLK_DIV),
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_in   (clk_in),
        .reset_n  (reset_n),
        .start    (start),
        .stop     (stop),
        .song_len (song_len),
`ifdef SAMPLE_VOLUME_EN
        .volume   (volume),
`endif
        .bus      (bus),
        .PWM_out  (PWM_out),
        .play     (play),
        .busy     (busy),
        .underrun (underrun)
    );

    always #10 clk_in = ~clk_in;

    // Memory model: 1 = answer after ack_delay cycles of request, 2 = ack plus stop
    // on the next request, 3 = one stray ack with no request outstanding.
    always @(negedge clk_in) begin
        if (ack_drv || stop) begin
            ack_drv   = 1'b0;
            stop      = 1'b0;
            resp_wait = 0;
        end else begin
            case (resp_mode)
                1: begin
                    if (bus.mem_req) begin
                        resp_wait = resp_wait + 1;
                        if (resp_wait >= ack_delay) begin
                            last_ack_addr = int'(bus.mem_addr);
                            data_drv      = song[bus.mem_addr[5:0]];
                            ack_drv       = 1'b1;
                        end
                    end else begin
                        resp_wait = 0;
                    end
                end
                2: begin
                    if (bus.mem_req && !abort_done) begin
                        data_drv   = 16'h1234;
                        ack_drv    = 1'b1;
                        stop       = 1'b1;
                        abort_done = 1'b1;
                    end
                end
                3: begin
                    if (!stray_done) begin
                        data_drv   = 16'h5555;
                        ack_drv    = 1'b1;
                        stray_done = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Reference conversion from plain arithmetic: optional gain, then bias by 32768.
    function automatic logic [15:0] expected_pwm(input logic [15:0] s);
        int v;
        v = int'($signed(s));
`ifdef SAMPLE_VOLUME_EN
        v = (v * (int'(volume) + 1)) >>> 4;
`endif
        return 16'(v + 32768);
    endfunction

    task automatic pulse_start(input int len);
        @(negedge clk_in);
        start    = 1'b1;
        song_len = ADDR_W'(len);
        @(negedge clk_in);
        start    = 1'b0;
    endtask

    task automatic play_song(input string name, input int n, input int delay,
                             input bit check_b2b, input bit restart_mid);
        logic [15:0] q[$];
        int          pushed   = 0;
        int          last_ack = -10;
        int          budget;
        bit          done     = 1'b0;
        bit          acked;
        logic [15:0] exp_pwm  = 16'h8000;
        logic        exp_play = 1'b0;
        logic        exp_busy = 1'b1;
        logic        exp_ur;
        budget    = n * (delay + 4) + (n + 2) * CLK_DIV * 2 + 50;
        ack_delay = delay;
        resp_mode = 1;
        @(negedge clk_in);
        start    = 1'b1;
        song_len = ADDR_W'(n);
        @(posedge clk_in);
        #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || bus.mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL %s start_edge: busy=%b req=%b, required busy=1 req=0", name, busy, bus.mem_req);
        end
        for (int cyc = 1; cyc < budget && !done; cyc++) begin
            @(posedge clk_in);
            acked = ack_drv;
            #1;
            exp_ur = 1'b0;
            if (cyc % CLK_DIV == 0) begin
                if (q.size() > 0) begin
                    exp_pwm  = expected_pwm(q.pop_front());
                    exp_play = 1'b1;
                end else if (pushed == n) begin
                    exp_pwm  = 16'h8000;
                    exp_play = 1'b0;
                    exp_busy = 1'b0;
                    done     = 1'b1;
                end else begin
                    exp_ur = 1'b1;
                end
            end
            if (acked) begin
                n_checks++;
                if (last_ack_addr != pushed) begin
                    n_fail++;
                    $display("FAIL %s mem_addr: got %0d, required %0d", name, last_ack_addr, pushed);
                end
                q.push_back(song[pushed]);
                pushed++;
                last_ack = cyc;
            end
            n_checks++;
            if (PWM_out !== exp_pwm || play !== exp_play || busy !== exp_busy || underrun !== exp_ur) begin
                n_fail++;
                $display("FAIL %s outputs cyc %0d: pwm=%h play=%b busy=%b ur=%b, required pwm=%h play=%b busy=%b ur=%b",
                         name, cyc, PWM_out, play, busy, underrun, exp_pwm, exp_play, exp_busy, exp_ur);
            end
            if (cyc == 1) begin
                n_checks++;
                if (bus.mem_req !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s first_req: req=%b two cycles after start, required 1", name, bus.mem_req);
                end
            end
            if (cyc == last_ack) begin
                n_checks++;
                if (bus.mem_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s req_drop cyc %0d: req=%b, required 0", name, cyc, bus.mem_req);
                end
            end
            if (check_b2b && cyc == last_ack + 1 && pushed < n) begin
                n_checks++;
                if (bus.mem_req !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s b2b_req cyc %0d: req=%b, required 1", name, cyc, bus.mem_req);
                end
            end
            if (restart_mid && cyc == 2 * CLK_DIV + 1) begin
                start    = 1'b1;
                song_len = ADDR_W'(n + 5);
            end else begin
                start = 1'b0;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: song did not end within %0d cycles", name, budget);
        end
        resp_mode = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk_in);
            #1;
            n_checks++;
            if (bus.mem_req !== 1'b0 || busy !== 1'b0 || PWM_out !== 16'h8000) begin
                n_fail++;
                $display("FAIL %s after_end: req=%b busy=%b pwm=%h, required 0 0 8000", name, bus.mem_req, busy, PWM_out);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk_in);
        #1;
        n_checks++;
        if (PWM_out !== 16'h8000 || play !== 1'b0 || busy !== 1'b0 || bus.mem_req !== 1'b0 ||
            bus.mem_addr !== '0 || underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: pwm=%h play=%b busy=%b req=%b addr=%h ur=%b, required 8000 0 0 0 00 0",
                     PWM_out, play, busy, bus.mem_req, bus.mem_addr, underrun);
        end
        @(negedge clk_in);
        reset_n = 1'b1;
        repeat (2) @(posedge clk_in);
    endtask

    task automatic test_basic();
        song[0] = 16'h0000;
        song[1] = 16'h7FFF;
        song[2] = 16'h8000;
        play_song("basic", 3, 1, 1'b1, 1'b0);
    endtask

    task automatic test_random_songs();
        for (int s = 0; s < 3; s++) begin
            int n;
            int d;
            n = int'($urandom_range(4, 20));
            d = int'($urandom_range(1, 3));
            for (int i = 0; i < n; i++) song[i] = 16'($urandom);
            song[0] = (s == 0) ? 16'h8000 : song[0];
            play_song("random", n, d, 1'b0, 1'b0);
        end
    endtask

    task automatic test_underrun();
        for (int i = 0; i < 6; i++) song[i] = 16'($urandom);
        play_song("underrun", 6, 20, 1'b0, 1'b0);
    endtask

    task automatic test_ignored_start();
        pulse_start(0);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk_in);
            #1;
            n_checks++;
            if (busy !== 1'b0 || bus.mem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL zero_len_start: busy=%b req=%b, required 0 0", busy, bus.mem_req);
            end
        end
        for (int i = 0; i < 7; i++) song[i] = 16'($urandom);
        play_song("start_while_busy", 7, 2, 1'b0, 1'b1);
    endtask

    task automatic test_stop();
        bit fired = 1'b0;
        for (int i = 0; i < 40; i++) song[i] = 16'($urandom);
        ack_delay = 1;
        resp_mode = 1;
        pulse_start(40);
        repeat (2 * CLK_DIV + 2) @(posedge clk_in);
        #1;
        n_checks++;
        if (play !== 1'b1) begin
            n_fail++;
            $display("FAIL stop_pre: play=%b, required 1", play);
        end
        resp_mode = 2;
        for (int k = 0; k < 40 && !fired; k++) begin
            @(posedge clk_in);
            if (stop) fired = 1'b1;
        end
        #1;
        n_checks++;
        if (!fired) begin
            n_fail++;
            $display("FAIL stop_timeout: no request seen to abort, required one within 40 cycles");
        end else if (bus.mem_req !== 1'b0 || busy !== 1'b0 || play !== 1'b0 ||
                     PWM_out !== 16'h8000 || underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL stop: req=%b busy=%b play=%b pwm=%h ur=%b, required 0 0 0 8000 0",
                     bus.mem_req, busy, play, PWM_out, underrun);
        end
        resp_mode = 3;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk_in);
            #1;
            n_checks++;
            if (bus.mem_req !== 1'b0 || busy !== 1'b0 || play !== 1'b0 || PWM_out !== 16'h8000) begin
                n_fail++;
                $display("FAIL late_ack: req=%b busy=%b play=%b pwm=%h, required 0 0 0 8000",
                         bus.mem_req, busy, play, PWM_out);
            end
        end
        resp_mode = 0;
        for (int i = 0; i < 5; i++) song[i] = 16'($urandom);
        play_song("after_stop", 5, 1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 10; i++) song[i] = 16'($urandom);
        ack_delay = 1;
        resp_mode = 1;
        pulse_start(10);
        repeat (3 * CLK_DIV + 3) @(posedge clk_in);
        #5;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (PWM_out !== 16'h8000 || play !== 1'b0 || busy !== 1'b0 || bus.mem_req !== 1'b0 ||
            bus.mem_addr !== '0 || underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: pwm=%h play=%b busy=%b req=%b addr=%h ur=%b, required 8000 0 0 0 00 0",
                     PWM_out, play, busy, bus.mem_req, bus.mem_addr, underrun);
        end
        @(negedge clk_in);
        reset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk_in);
            #1;
            n_checks++;
            if (bus.mem_req !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_quiet: req=%b busy=%b, required 0 0", bus.mem_req, busy);
            end
        end
        resp_mode = 0;
    endtask

`ifdef SAMPLE_VOLUME_EN
    task automatic test_volume();
        volume  = 4'd7;
        song[0] = 16'h4000;
        play_song("volume7", 1, 1, 1'b0, 1'b0);
        volume  = 4'd0;
        song[0] = 16'hFFFF;
        play_song("volume0", 1, 1, 1'b0, 1'b0);
        volume  = 4'($urandom);
        for (int i = 0; i < 6; i++) song[i] = 16'($urandom);
        play_song("volume_rand", 6, 2, 1'b0, 1'b0);
        volume  = 4'd15;
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_random_songs();
        test_underrun();
        test_ignored_start();
        test_stop();
        test_reset_mid();
`ifdef SAMPLE_VOLUME_EN
        test_volume();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/audio_sample_feeder.md
# audio_sample_feeder

Upstream stage of the PWM audio DAC: streams 16-bit signed PCM samples from a song memory, buffers them in a small FIFO, and presents one offset-binary sample per sample period on `PWM_out`, together with the `play` gate the DAC consumes. A divided sample-rate tick paces output. Memory is read through a single-outstanding request/acknowledge handshake.

## Interface
- `CLK_DIV`, 2267: clock cycles per sample period (50 MHz / 22.05 kHz); legal range ≥ 8.
- `ADDR_W`, 18: song memory address width.
- `FIFO_DEPTH`, 8: sample FIFO entries; power of two, ≥ 2.
- `clk_in`  in  1  system clock, all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse: begin playback from address 0.
- `stop`  in  1  one-cycle pulse: abort playback.
- `song_len`  in  ADDR_W  number of samples; sampled on accepted `start`.
- `volume`  in  4  gain step, 15 = unity (present only with `SAMPLE_VOLUME_EN`).
- `mem_addr`  out  ADDR_W  sample address being requested.
- `mem_req`  out  1  read request, held until acknowledged.
- `mem_ack`  in  1  read data valid on `mem_data` this cycle.
- `mem_data`  in  16  signed two's-complement sample.
- `PWM_out`  out  16  unsigned offset-binary sample to the DAC's `PWM_in`.
- `play`  out  1  DAC enable.
- `busy`  out  1  playback in progress.
- `underrun`  out  1  one-cycle pulse: tick arrived with FIFO empty mid-song.

## Operation
- Reset values: `PWM_out`=16'h8000, `play`=0, `busy`=0, `mem_req`=0, `mem_addr`=0, `underrun`=0; FIFO empty; state IDLE; tick counter 0.
- States: IDLE, FETCH, WAIT, DRAIN.
- IDLE: `start` with `song_len`≠0 latches length, clears FIFO, tick counter and fetch address, sets `busy`, enters FETCH. `start` with `song_len`=0 ignored. `start` outside IDLE ignored.
- FETCH: if FIFO free slots > 0, assert `mem_req` with `mem_addr`=fetch address, go WAIT; else stay.
- WAIT: `mem_req` and `mem_addr` stable. On `mem_ack`: write `mem_data` to FIFO, drop `mem_req` same edge, increment address; if address now = length go DRAIN, else FETCH. `mem_ack` while `mem_req`=0 ignored.
- Tick: counter counts 0..CLK_DIV-1, pulses on CLK_DIV-1 and wraps; only runs while `busy`.
- On tick with FIFO non-empty: pop, `PWM_out` <= conversion of popped sample, `play`<=1.
- On tick with FIFO empty in FETCH/WAIT: `underrun` pulse, `PWM_out` and `play` hold.
- On tick with FIFO empty in DRAIN: `PWM_out`<=16'h8000, `play`<=0, `busy`<=0, IDLE.
- Conversion: offset = {~s[15], s[14:0]} (two's complement to offset binary, 0 → 16'h8000, -32768 → 16'h0000, 32767 → 16'hFFFF).
- FIFO push and pop in the same cycle both take effect; occupancy unchanged.
- `stop` (any state, highest priority, beats simultaneous `start`/`mem_ack`): next edge IDLE, FIFO flushed, `mem_req`=0, `play`=0, `busy`=0, `PWM_out`=16'h8000. A late `mem_ack` after abort is ignored.

## Timing
- First request: `mem_req` rises 2 cycles after `start` (IDLE→FETCH, FETCH→WAIT).
- Back-to-back ack: next `mem_req` rises 2 cycles after the ack cycle.
- First sample on `PWM_out` and `play`=1: registered at the edge ending cycle CLK_DIV after `start`, provided ≥1 fetch completed.
- `PWM_out` changes only on ticks, `stop`, or reset; never glitches between ticks.
- Song of N samples with no underrun: `busy` falls at tick N+1 (≈(N+1)·CLK_DIV cycles after `start`).
- Underrun does not drop or reorder samples; the late sample plays at the next tick.

## Configuration
- `SAMPLE_VOLUME_EN` defined: `volume` port exists; before conversion s' = (s × (volume+1)) >>> 4, signed 16×5 multiply, arithmetic shift, result 16 bits (volume=15 → s' = s exact, volume=0 → s/16 rounded toward −∞). Scaling happens on pop, registered into `PWM_out` at the tick.
- Undefined: no `volume` port, no multiplier; s' = s.

## Test plan
- Reset mid-playback -> all outputs at reset values immediately, no further `mem_req` until new `start`.
- CLK_DIV=8, song_len=3, samples 0, 16'h7FFF, 16'h8000, ack 1 cycle after req -> `PWM_out` 16'h8000, 16'hFFFF, 16'h0000 at ticks 1-3; at tick 4 `play`=0, `busy`=0, `PWM_out`=16'h8000.
- CLK_DIV=8, ack delayed 20 cycles -> `underrun` pulses at ticks where FIFO empty; output sequence still matches memory order, no sample lost.
- `stop` asserted with `mem_req` high and ack on the same cycle -> IDLE next edge, FIFO empty, sample not written, `play`=0.
- `start` with song_len=0, and `start` while busy -> both ignored; no `mem_req`, state unchanged.
- `SAMPLE_VOLUME_EN`, volume=7, sample 16'h4000 -> `PWM_out`=16'hA000; volume=0, sample 16'hFFFF (−1) -> `PWM_out`=16'h7FFF.
